// File: rtl/rv32_decode_execute.sv
// ----------------------------------------------------------------------------
// rv32_decode_execute
// RV32I decode/execute stage. It decodes the instruction into datapath
// selects and memory strobes, runs the ALU, resolves the branch and
// registers everything in a single output stage (latency 1).
//
// Ports
//   clk            in   1      clock, all state on rising edge
//   rst            in   1      synchronous, active-high reset
//   in_valid       in   1      instr/operands valid this cycle
//   instr          in   XLEN   instruction word
//   pc             in   XLEN   address of instr
//   rs1_value      in   XLEN   rs1 contents
//   rs2_value      in   XLEN   rs2 contents
//   imm            in   XLEN   sign-extended immediate
//   out_valid      out  1      registered outputs are valid
//   alu_op         out  4      ALU operation
//   reg_write_en   out  1      write rd at writeback
//   alu_a_src      out  1      1 = rs1_value, 0 = pc
//   alu_b_src      out  1      1 = rs2_value, 0 = imm
//   branch_cond    out  3      branch condition
//   rd_src         out  2      00 alu_out, 01 mem/IO data, 10 pc+4
//   data_read_en   out  1      load strobe
//   data_write_en  out  1      store strobe
//   data_size      out  3      funct3 for loads/stores, else 0
//   alu_out        out  XLEN   ALU result / address / branch target
//   branch         out  1      PC redirect taken
//   pc_next        out  XLEN   next PC
//
// Handshake: in_valid qualifies the inputs at a rising edge; out_valid is
// high for exactly the cycle after such an edge. There is no backpressure.
// ----------------------------------------------------------------------------
module rv32_decode_execute #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   input  logic [XLEN-1:0] instr,
   input  logic [XLEN-1:0] pc,
   input  logic [XLEN-1:0] rs1_value,
   input  logic [XLEN-1:0] rs2_value,
   input  logic [XLEN-1:0] imm,
   output logic            out_valid,
   output logic [3:0]      alu_op,
   output logic            reg_write_en,
   output logic            alu_a_src,
   output logic            alu_b_src,
   output logic [2:0]      branch_cond,
   output logic [1:0]      rd_src,
   output logic            data_read_en,
   output logic            data_write_en,
   output logic [2:0]      data_size,
   output logic [XLEN-1:0] alu_out,
   output logic            branch,
   output logic [XLEN-1:0] pc_next
);

   localparam logic [3:0] ALU_ADD   = 4'b0000;
   localparam logic [3:0] ALU_SUB   = 4'b1000;
   localparam logic [3:0] ALU_SLL   = 4'b0001;
   localparam logic [3:0] ALU_SLT   = 4'b0010;
   localparam logic [3:0] ALU_SLTU  = 4'b0011;
   localparam logic [3:0] ALU_XOR   = 4'b0100;
   localparam logic [3:0] ALU_SRL   = 4'b0101;
   localparam logic [3:0] ALU_SRA   = 4'b1101;
   localparam logic [3:0] ALU_OR    = 4'b0110;
   localparam logic [3:0] ALU_AND   = 4'b0111;
   localparam logic [3:0] ALU_PASSB = 4'b1111;

   localparam logic [2:0] COND_EQ     = 3'b000;
   localparam logic [2:0] COND_NE     = 3'b001;
   localparam logic [2:0] COND_NEVER  = 3'b010;
   localparam logic [2:0] COND_ALWAYS = 3'b011;
   localparam logic [2:0] COND_LT     = 3'b100;
   localparam logic [2:0] COND_GE     = 3'b101;
   localparam logic [2:0] COND_LTU    = 3'b110;
   localparam logic [2:0] COND_GEU    = 3'b111;

   logic [6:0] opcode;
   logic [2:0] f3;
   logic       f7_5;
   assign opcode = instr[6:0];
   assign f3     = instr[14:12];
   assign f7_5   = instr[30];

   // Register/rd fields are consumed upstream; only opcode/funct bits matter here.
   logic unused_instr_bits;
   assign unused_instr_bits = ^{instr[31], instr[29:15], instr[11:7]};

   // ---------------- control decode ----------------
   logic [3:0] alu_op_d;
   logic       reg_write_en_d, alu_a_src_d, alu_b_src_d;
   logic [2:0] branch_cond_d, data_size_d;
   logic [1:0] rd_src_d;
   logic       data_read_en_d, data_write_en_d;

   always_comb begin
      alu_op_d        = ALU_ADD;
      reg_write_en_d  = 1'b0;
      alu_a_src_d     = 1'b0;
      alu_b_src_d     = 1'b0;
      branch_cond_d   = COND_NEVER;
      rd_src_d        = 2'b00;
      data_read_en_d  = 1'b0;
      data_write_en_d = 1'b0;
      data_size_d     = 3'b000;
      case (opcode)
         7'b0110011: begin  // OP
            alu_op_d       = {f7_5, f3};
            alu_a_src_d    = 1'b1;
            alu_b_src_d    = 1'b1;
            reg_write_en_d = 1'b1;
         end
         7'b0010011: begin  // OP-IMM: bit 30 only selects SRAI vs SRLI
            alu_op_d       = {(f3 == 3'b101) ? f7_5 : 1'b0, f3};
            alu_a_src_d    = 1'b1;
            reg_write_en_d = 1'b1;
         end
         7'b0000011: begin  // LOAD
            alu_a_src_d    = 1'b1;
            reg_write_en_d = 1'b1;
            rd_src_d       = 2'b01;
            data_read_en_d = 1'b1;
            data_size_d    = f3;
         end
         7'b0100011: begin  // STORE
            alu_a_src_d     = 1'b1;
            data_write_en_d = 1'b1;
            data_size_d     = f3;
         end
         7'b1100011: begin  // BRANCH: funct3 010/011 are not real branches
            branch_cond_d = (f3[2:1] == 2'b01) ? COND_NEVER : f3;
         end
         7'b1101111: begin  // JAL
            branch_cond_d  = COND_ALWAYS;
            reg_write_en_d = 1'b1;
            rd_src_d       = 2'b10;
         end
         7'b1100111: begin  // JALR
            alu_a_src_d    = 1'b1;
            branch_cond_d  = COND_ALWAYS;
            reg_write_en_d = 1'b1;
            rd_src_d       = 2'b10;
         end
         7'b0110111: begin  // LUI
            alu_op_d       = ALU_PASSB;
            reg_write_en_d = 1'b1;
         end
         7'b0010111: begin  // AUIPC
            reg_write_en_d = 1'b1;
         end
         default: ;         // NOP
      endcase
   end

   // ---------------- ALU ----------------
   logic [XLEN-1:0] alu_a, alu_b, alu_out_d;
   logic [4:0]      shamt;
   assign alu_a = alu_a_src_d ? rs1_value : pc;
   assign alu_b = alu_b_src_d ? rs2_value : imm;
   assign shamt = alu_b[4:0];

   always_comb begin
      alu_out_d = '0;
      case (alu_op_d)
         ALU_ADD:   alu_out_d = alu_a + alu_b;
         ALU_SUB:   alu_out_d = alu_a - alu_b;
         ALU_SLL:   alu_out_d = alu_a << shamt;
         ALU_SLT:   alu_out_d = {{(XLEN-1){1'b0}}, $signed(alu_a) < $signed(alu_b)};
         ALU_SLTU:  alu_out_d = {{(XLEN-1){1'b0}}, alu_a < alu_b};
         ALU_XOR:   alu_out_d = alu_a ^ alu_b;
         ALU_SRL:   alu_out_d = alu_a >> shamt;
         ALU_SRA:   alu_out_d = XLEN'($signed(alu_a) >>> shamt);
         ALU_OR:    alu_out_d = alu_a | alu_b;
         ALU_AND:   alu_out_d = alu_a & alu_b;
         ALU_PASSB: alu_out_d = alu_b;
         default:   alu_out_d = '0;
      endcase
   end

   // ---------------- branch resolution ----------------
   logic            branch_d;
   logic [XLEN-1:0] pc_plus4, pc_next_d;
   assign pc_plus4 = pc + XLEN'(4);

   always_comb begin
      branch_d = 1'b0;
      case (branch_cond_d)
         COND_EQ:     branch_d = (rs1_value == rs2_value);
         COND_NE:     branch_d = (rs1_value != rs2_value);
         COND_LT:     branch_d = ($signed(rs1_value) <  $signed(rs2_value));
         COND_GE:     branch_d = ($signed(rs1_value) >= $signed(rs2_value));
         COND_LTU:    branch_d = (rs1_value <  rs2_value);
         COND_GEU:    branch_d = (rs1_value >= rs2_value);
         COND_ALWAYS: branch_d = 1'b1;
         default:     branch_d = 1'b0;
      endcase
   end

   // Bit 0 cleared on redirect so JALR targets are halfword aligned.
   assign pc_next_d = branch_d ? {alu_out_d[XLEN-1:1], 1'b0} : pc_plus4;

   // ---------------- output register ----------------
   logic            out_valid_q, reg_write_en_q, alu_a_src_q, alu_b_src_q;
   logic            data_read_en_q, data_write_en_q, branch_q;
   logic [3:0]      alu_op_q;
   logic [2:0]      branch_cond_q, data_size_q;
   logic [1:0]      rd_src_q;
   logic [XLEN-1:0] alu_out_q, pc_next_q;

   // A bubble clears the side-effecting outputs; the datapath fields hold.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q     <= 1'b0;
         alu_op_q        <= '0;
         reg_write_en_q  <= 1'b0;
         alu_a_src_q     <= 1'b0;
         alu_b_src_q     <= 1'b0;
         branch_cond_q   <= '0;
         rd_src_q        <= '0;
         data_read_en_q  <= 1'b0;
         data_write_en_q <= 1'b0;
         data_size_q     <= '0;
         alu_out_q       <= '0;
         branch_q        <= 1'b0;
         pc_next_q       <= '0;
      end else if (in_valid) begin
         out_valid_q     <= 1'b1;
         alu_op_q        <= alu_op_d;
         reg_write_en_q  <= reg_write_en_d;
         alu_a_src_q     <= alu_a_src_d;
         alu_b_src_q     <= alu_b_src_d;
         branch_cond_q   <= branch_cond_d;
         rd_src_q        <= rd_src_d;
         data_read_en_q  <= data_read_en_d;
         data_write_en_q <= data_write_en_d;
         data_size_q     <= data_size_d;
         alu_out_q       <= alu_out_d;
         branch_q        <= branch_d;
         pc_next_q       <= pc_next_d;
      end else begin
         out_valid_q     <= 1'b0;
         reg_write_en_q  <= 1'b0;
         rd_src_q        <= '0;
         data_read_en_q  <= 1'b0;
         data_write_en_q <= 1'b0;
         branch_q        <= 1'b0;
      end
   end

   assign out_valid     = out_valid_q;
   assign alu_op        = alu_op_q;
   assign reg_write_en  = reg_write_en_q;
   assign alu_a_src     = alu_a_src_q;
   assign alu_b_src     = alu_b_src_q;
   assign branch_cond   = branch_cond_q;
   assign rd_src        = rd_src_q;
   assign data_read_en  = data_read_en_q;
   assign data_write_en = data_write_en_q;
   assign data_size     = data_size_q;
   assign alu_out       = alu_out_q;
   assign branch        = branch_q;
   assign pc_next       = pc_next_q;

endmodule

// File: tb/tb_rv32_decode_execute.sv
// ----------------------------------------------------------------------------
// tb_rv32_decode_execute
// Directed bench for rv32_decode_execute: each step drives one instruction
// on the falling edge and checks the registered outputs 1 ns after the next
// rising edge against hand-computed values.
// ----------------------------------------------------------------------------
module tb_rv32_decode_execute;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic [31:0] instr, pc, rs1_value, rs2_value, imm;
   logic        out_valid, reg_write_en, alu_a_src, alu_b_src;
   logic        data_read_en, data_write_en, branch;
   logic [3:0]  alu_op;
   logic [2:0]  branch_cond, data_size;
   logic [1:0]  rd_src;
   logic [31:0] alu_out, pc_next;

   int vectors = 0;
   int errors  = 0;

   rv32_decode_execute #(.XLEN(32)) dut (
      .clk           (clk),
      .rst           (rst),
      .in_valid      (in_valid),
      .instr         (instr),
      .pc            (pc),
      .rs1_value     (rs1_value),
      .rs2_value     (rs2_value),
      .imm           (imm),
      .out_valid     (out_valid),
      .alu_op        (alu_op),
      .reg_write_en  (reg_write_en),
      .alu_a_src     (alu_a_src),
      .alu_b_src     (alu_b_src),
      .branch_cond   (branch_cond),
      .rd_src        (rd_src),
      .data_read_en  (data_read_en),
      .data_write_en (data_write_en),
      .data_size     (data_size),
      .alu_out       (alu_out),
      .branch        (branch),
      .pc_next       (pc_next)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- checkers ----------------
   task automatic chk1(input string tag, input logic obs, input logic exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic chk2(input string tag, input logic [1:0] obs, input logic [1:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic chk3(input string tag, input logic [2:0] obs, input logic [2:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // ---------------- driver ----------------
   task automatic step(input logic v, input logic [31:0] i, input logic [31:0] p,
                       input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] im);
      @(negedge clk);
      in_valid  = v;
      instr     = i;
      pc        = p;
      rs1_value = r1;
      rs2_value = r2;
      imm       = im;
      @(posedge clk);
      #1;
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      rst = 1'b1;
      in_valid = 1'b0;
      instr = '0; pc = '0; rs1_value = '0; rs2_value = '0; imm = '0;
      repeat (2) @(posedge clk);
      #1;
      chk1 ("rst.out_valid", out_valid, 1'b0);
      chk32("rst.alu_out",   alu_out,   32'h0);
      chk32("rst.pc_next",   pc_next,   32'h0);
      chk3 ("rst.cond",      branch_cond, 3'b000);
      @(negedge clk);
      rst = 1'b0;

      // add x3,x1,x2
      step(1'b1, 32'h002081B3, 32'h1000, 32'd7, 32'd5, 32'h0);
      chk1 ("add.out_valid", out_valid,    1'b1);
      chk32("add.alu_out",   alu_out,      32'd12);
      chk1 ("add.wr",        reg_write_en, 1'b1);
      chk2 ("add.rd_src",    rd_src,       2'b00);
      chk1 ("add.branch",    branch,       1'b0);
      chk32("add.pc_next",   pc_next,      32'h1004);
      chk4 ("add.alu_op",    alu_op,       4'b0000);
      chk1 ("add.a_src",     alu_a_src,    1'b1);
      chk1 ("add.b_src",     alu_b_src,    1'b1);
      chk3 ("add.cond",      branch_cond,  3'b010);

      // sub wraps
      step(1'b1, 32'h402081B3, 32'h1004, 32'd0, 32'd1, 32'h0);
      chk32("sub.alu_out", alu_out, 32'hFFFFFFFF);
      chk4 ("sub.alu_op",  alu_op,  4'b1000);

      // srai x3,x1,4 (imm field 0x404, shift uses low 5 bits)
      step(1'b1, 32'h4040D193, 32'h1008, 32'h80000000, 32'h0, 32'h00000404);
      chk32("srai.alu_out", alu_out,   32'hF8000000);
      chk4 ("srai.alu_op",  alu_op,    4'b1101);
      chk1 ("srai.b_src",   alu_b_src, 1'b0);

      // beq +8 taken
      step(1'b1, 32'h00208463, 32'h100, 32'd3, 32'd3, 32'd8);
      chk1 ("beq_t.branch",  branch,       1'b1);
      chk32("beq_t.pc_next", pc_next,      32'h108);
      chk3 ("beq_t.cond",    branch_cond,  3'b000);
      chk1 ("beq_t.wr",      reg_write_en, 1'b0);
      chk1 ("beq_t.a_src",   alu_a_src,    1'b0);

      // beq +8 not taken
      step(1'b1, 32'h00208463, 32'h100, 32'd3, 32'd4, 32'd8);
      chk1 ("beq_n.branch",  branch,  1'b0);
      chk32("beq_n.pc_next", pc_next, 32'h104);

      // blt signed: -1 < 1 taken
      step(1'b1, 32'h0020C463, 32'h200, 32'hFFFFFFFF, 32'd1, 32'd8);
      chk1 ("blt.branch",  branch,  1'b1);
      chk32("blt.pc_next", pc_next, 32'h208);

      // bltu unsigned: 0xFFFFFFFF < 1 not taken
      step(1'b1, 32'h0020E463, 32'h200, 32'hFFFFFFFF, 32'd1, 32'd8);
      chk1 ("bltu.branch",  branch,      1'b0);
      chk32("bltu.pc_next", pc_next,     32'h204);
      chk3 ("bltu.cond",    branch_cond, 3'b110);

      // jalr x1,3(x5): odd target, bit 0 cleared in pc_next
      step(1'b1, 32'h003280E7, 32'h400, 32'h200, 32'h0, 32'd3);
      chk32("jalr.alu_out", alu_out,      32'h203);
      chk32("jalr.pc_next", pc_next,      32'h202);
      chk2 ("jalr.rd_src",  rd_src,       2'b10);
      chk1 ("jalr.wr",      reg_write_en, 1'b1);
      chk1 ("jalr.branch",  branch,       1'b1);
      chk3 ("jalr.cond",    branch_cond,  3'b011);

      // jal +8
      step(1'b1, 32'h008000EF, 32'h300, 32'h0, 32'h0, 32'd8);
      chk32("jal.pc_next", pc_next, 32'h308);
      chk2 ("jal.rd_src",  rd_src,  2'b10);

      // bubble right after a taken jump clears side effects
      step(1'b0, 32'h008000EF, 32'h300, 32'h0, 32'h0, 32'd8);
      chk1("bub.out_valid", out_valid,    1'b0);
      chk1("bub.wr",        reg_write_en, 1'b0);
      chk1("bub.branch",    branch,       1'b0);
      chk2("bub.rd_src",    rd_src,       2'b00);

      // lui
      step(1'b1, 32'h123452B7, 32'h500, 32'h0000DEAD, 32'h0, 32'h12345000);
      chk32("lui.alu_out", alu_out,      32'h12345000);
      chk4 ("lui.alu_op",  alu_op,       4'b1111);
      chk1 ("lui.wr",      reg_write_en, 1'b1);
      chk32("lui.pc_next", pc_next,      32'h504);

      // auipc
      step(1'b1, 32'h00001297, 32'h500, 32'h0, 32'h0, 32'h00001000);
      chk32("auipc.alu_out", alu_out, 32'h1500);
      chk1 ("auipc.branch",  branch,  1'b0);

      // sw x2,8(x1) -> address 0x20008
      step(1'b1, 32'h00202423, 32'h600, 32'h00020000, 32'h55, 32'd8);
      chk32("sw.alu_out",  alu_out,       32'h00020008);
      chk1 ("sw.write_en", data_write_en, 1'b1);
      chk1 ("sw.read_en",  data_read_en,  1'b0);
      chk3 ("sw.size",     data_size,     3'b010);
      chk1 ("sw.wr",       reg_write_en,  1'b0);

      // lbu x3,4(x1)
      step(1'b1, 32'h0040C183, 32'h604, 32'h1000, 32'h0, 32'd4);
      chk32("lbu.alu_out", alu_out,       32'h1004);
      chk1 ("lbu.read_en", data_read_en,  1'b1);
      chk1 ("lbu.write_en",data_write_en, 1'b0);
      chk2 ("lbu.rd_src",  rd_src,        2'b01);
      chk3 ("lbu.size",    data_size,     3'b100);

      // slt / sltu on -1 vs 1
      step(1'b1, 32'h0020A1B3, 32'h608, 32'hFFFFFFFF, 32'd1, 32'h0);
      chk32("slt.alu_out", alu_out, 32'd1);
      step(1'b1, 32'h0020B1B3, 32'h60C, 32'hFFFFFFFF, 32'd1, 32'h0);
      chk32("sltu.alu_out", alu_out, 32'd0);

      // illegal opcode behaves as NOP
      step(1'b1, 32'hFFFFFFFF, 32'h700, 32'd1, 32'd1, 32'hFFFFFFFF);
      chk1 ("ill.wr",       reg_write_en,  1'b0);
      chk1 ("ill.read_en",  data_read_en,  1'b0);
      chk1 ("ill.write_en", data_write_en, 1'b0);
      chk1 ("ill.branch",   branch,        1'b0);
      chk32("ill.pc_next",  pc_next,       32'h704);
      chk4 ("ill.alu_op",   alu_op,        4'b0000);
      chk3 ("ill.cond",     branch_cond,   3'b010);

      // reset mid-stream overrides a valid instruction
      @(negedge clk);
      rst = 1'b1;
      step(1'b1, 32'h002081B3, 32'h800, 32'd7, 32'd5, 32'h0);
      chk1 ("mrst.out_valid", out_valid,    1'b0);
      chk1 ("mrst.wr",        reg_write_en, 1'b0);
      chk32("mrst.alu_out",   alu_out,      32'h0);
      chk32("mrst.pc_next",   pc_next,      32'h0);
      @(negedge clk);
      rst = 1'b0;

      // recovery after reset
      step(1'b1, 32'h002081B3, 32'h800, 32'd20, 32'd22, 32'h0);
      chk1 ("rec.out_valid", out_valid, 1'b1);
      chk32("rec.alu_out",   alu_out,   32'd42);
      chk32("rec.pc_next",   pc_next,   32'h804);

      @(negedge clk);
      in_valid = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
